// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues word addresses to instruction memory,
// waits a fixed latency, captures the IR and exposes its decoded fields.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'd0,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned MEM_DEPTH   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        busy,
  output logic        ir_valid,
  output logic [31:0] ir,
  output logic [31:0] pc,
  output logic [31:0] pc_fetched,
  output logic [31:0] pc_plus1,
  output logic [5:0]  opcode,
  output logic [3:0]  rd,
  output logic [3:0]  rs1,
  output logic [3:0]  rs2,
  output logic [1:0]  mode,
  output logic [31:0] imm_sext,
  output logic [31:0] joff_sext,
  output logic        fault
);

  localparam int unsigned CNT_W = 4;
  localparam logic [31:0] DEPTH = 32'(MEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        ir_q, ir_d;
  logic [31:0]        pcf_q, pcf_d;
  logic               irv_q, irv_d;
  logic               busy_q, busy_d;
  logic               fault_q, fault_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pend_v_q, pend_v_d;
  logic [31:0]        pend_pc_q, pend_pc_d;

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      addr_q    <= RESET_PC;
      ir_q      <= 32'd0;
      pcf_q     <= 32'd0;
      irv_q     <= 1'b0;
      busy_q    <= 1'b0;
      fault_q   <= 1'b0;
      cnt_q     <= '0;
      pend_v_q  <= 1'b0;
      pend_pc_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      ir_q      <= ir_d;
      pcf_q     <= pcf_d;
      irv_q     <= irv_d;
      busy_q    <= busy_d;
      fault_q   <= fault_d;
      cnt_q     <= cnt_d;
      pend_v_q  <= pend_v_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  // Next-state and next-register logic
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    ir_d      = ir_q;
    pcf_d     = pcf_q;
    irv_d     = 1'b0;
    busy_d    = busy_q;
    fault_d   = fault_q;
    cnt_d     = cnt_q;
    pend_v_d  = pend_v_q;
    pend_pc_d = pend_pc_q;

    case (state_q)
      IDLE: begin
        // A redirect wins over a fetch request in the same cycle
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end else if (fetch_req) begin
          if (pc_q < DEPTH) begin
            addr_d  = pc_q;
            cnt_d   = CNT_W'(MEM_LATENCY);
            busy_d  = 1'b1;
            state_d = WAIT;
          end else begin
            fault_d = 1'b1;
            state_d = FAULT;
          end
        end
      end

      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (redirect_valid) begin
          pend_v_d  = 1'b1;
          pend_pc_d = redirect_pc;
        end
        if (cnt_q == CNT_W'(1)) begin
          ir_d     = imem_data;
          pcf_d    = addr_q;
          irv_d    = 1'b1;
          busy_d   = 1'b0;
          pend_v_d = 1'b0;
          state_d  = IDLE;
          // Most recent redirect (this cycle, else held) replaces sequential pc+1
          if (redirect_valid) begin
            pc_d = redirect_pc;
          end else if (pend_v_q) begin
            pc_d = pend_pc_q;
          end else begin
            pc_d = pc_q + 32'd1;
          end
        end
      end

      FAULT: begin
        busy_d = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign imem_addr  = addr_q;
  assign busy       = busy_q;
  assign ir_valid   = irv_q;
  assign ir         = ir_q;
  assign pc         = pc_q;
  assign pc_fetched = pcf_q;
  assign fault      = fault_q;

  // Decoded fields; formats overlap and the control unit picks by opcode
  assign pc_plus1  = pcf_q + 32'd1;
  assign opcode    = ir_q[31:26];
  assign rd        = ir_q[25:22];
  assign rs1       = ir_q[21:18];
  assign rs2       = ir_q[17:14];
  assign mode      = ir_q[17:16];
  assign imm_sext  = {{16{ir_q[15]}}, ir_q[15:0]};
  assign joff_sext = {{6{ir_q[25]}}, ir_q[25:0]};

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: one instance at latency 1, one at latency 3,
// both backed by a shared bench-owned instruction memory.
module tb_instr_fetch_unit;

  logic clk;
  logic reset;

  logic [31:0] mem [0:1023];

  // Latency-1 instance
  logic        a_fetch_req, a_redirect_valid;
  logic [31:0] a_redirect_pc, a_imem_addr, a_imem_data;
  logic        a_busy, a_ir_valid, a_fault;
  logic [31:0] a_ir, a_pc, a_pc_fetched, a_pc_plus1, a_imm_sext, a_joff_sext;
  logic [5:0]  a_opcode;
  logic [3:0]  a_rd, a_rs1, a_rs2;
  logic [1:0]  a_mode;

  // Latency-3 instance
  logic        b_fetch_req, b_redirect_valid;
  logic [31:0] b_redirect_pc, b_imem_addr, b_imem_data;
  logic        b_busy, b_ir_valid, b_fault;
  logic [31:0] b_ir, b_pc, b_pc_fetched, b_pc_plus1, b_imm_sext, b_joff_sext;
  logic [5:0]  b_opcode;
  logic [3:0]  b_rd, b_rs1, b_rs2;
  logic [1:0]  b_mode;

  int checks = 0;
  int errors = 0;

  assign a_imem_data = (a_imem_addr < 32'd1024) ? mem[a_imem_addr[9:0]] : 32'h0;
  assign b_imem_data = (b_imem_addr < 32'd1024) ? mem[b_imem_addr[9:0]] : 32'h0;

  instr_fetch_unit #(.RESET_PC(32'd0), .MEM_LATENCY(1), .MEM_DEPTH(1024)) dut_a (
    .clk(clk), .reset(reset), .fetch_req(a_fetch_req),
    .redirect_valid(a_redirect_valid), .redirect_pc(a_redirect_pc),
    .imem_addr(a_imem_addr), .imem_data(a_imem_data), .busy(a_busy),
    .ir_valid(a_ir_valid), .ir(a_ir), .pc(a_pc), .pc_fetched(a_pc_fetched),
    .pc_plus1(a_pc_plus1), .opcode(a_opcode), .rd(a_rd), .rs1(a_rs1), .rs2(a_rs2),
    .mode(a_mode), .imm_sext(a_imm_sext), .joff_sext(a_joff_sext), .fault(a_fault)
  );

  instr_fetch_unit #(.RESET_PC(32'd0), .MEM_LATENCY(3), .MEM_DEPTH(1024)) dut_b (
    .clk(clk), .reset(reset), .fetch_req(b_fetch_req),
    .redirect_valid(b_redirect_valid), .redirect_pc(b_redirect_pc),
    .imem_addr(b_imem_addr), .imem_data(b_imem_data), .busy(b_busy),
    .ir_valid(b_ir_valid), .ir(b_ir), .pc(b_pc), .pc_fetched(b_pc_fetched),
    .pc_plus1(b_pc_plus1), .opcode(b_opcode), .rd(b_rd), .rs1(b_rs1), .rs2(b_rs2),
    .mode(b_mode), .imm_sext(b_imm_sext), .joff_sext(b_joff_sext), .fault(b_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_b_valid(input string tag);
    int n;
    n = 0;
    while (!b_ir_valid && n < 40) begin
      tick();
      n++;
    end
    check(tag, 32'(b_ir_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int pulses, cyc, last, unstable, dbl;
    logic held, prev_v;
    logic [31:0] held_addr;

    for (int k = 0; k < 1024; k++) mem[k] = 32'hA000_0000 + 32'(k);
    mem[0]    = 32'h0404_8000;
    mem[2]    = 32'h0000_FFFC;
    mem[3]    = 32'h0C04_0004;
    mem[12]   = 32'h3000_0004;
    mem[1023] = 32'hDEAD_BEEF;

    reset = 1'b1;
    a_fetch_req = 1'b0; a_redirect_valid = 1'b0; a_redirect_pc = 32'd0;
    b_fetch_req = 1'b0; b_redirect_valid = 1'b0; b_redirect_pc = 32'd0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_pc", a_pc, 32'd0);
    check("rst_addr", a_imem_addr, 32'd0);
    check("rst_ir", a_ir, 32'd0);
    check("rst_irv", 32'(a_ir_valid), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_fault", 32'(a_fault), 32'd0);

    // L=1 single fetch of word 0
    a_fetch_req = 1'b1;
    tick();
    a_fetch_req = 1'b0;
    check("a_busy_acc", 32'(a_busy), 32'd1);
    check("a_irv_early", 32'(a_ir_valid), 32'd0);
    tick();
    check("a_irv", 32'(a_ir_valid), 32'd1);
    check("a_ir0", a_ir, 32'h0404_8000);
    check("a_opc0", 32'(a_opcode), 32'd1);
    check("a_rd0", 32'(a_rd), 32'd0);
    check("a_rs1_0", 32'(a_rs1), 32'd1);
    check("a_rs2_0", 32'(a_rs2), 32'd2);
    check("a_pc0", a_pc, 32'd1);
    check("a_pcf0", a_pc_fetched, 32'd0);
    check("a_pcp1_0", a_pc_plus1, 32'd1);
    check("a_busy_done", 32'(a_busy), 32'd0);
    tick();
    check("a_irv_pulse", 32'(a_ir_valid), 32'd0);

    // Words 1..3 on the L=1 instance
    for (int w = 1; w <= 3; w++) begin
      a_fetch_req = 1'b1;
      tick();
      a_fetch_req = 1'b0;
      tick();
      check("a_irv_w", 32'(a_ir_valid), 32'd1);
      if (w == 2) check("a_imm_neg", a_imm_sext, 32'hFFFF_FFFC);
    end
    check("a_ir3", a_ir, 32'h0C04_0004);
    check("a_opc3", 32'(a_opcode), 32'd3);
    check("a_rs1_3", 32'(a_rs1), 32'd1);
    check("a_mode3", 32'(a_mode), 32'd0);
    check("a_imm3", a_imm_sext, 32'd4);
    check("a_pc3", a_pc, 32'd4);

    // L=3 streaming with fetch_req held high
    pulses = 0; cyc = 0; last = 0; unstable = 0; dbl = 0;
    held = 1'b0; held_addr = 32'd0; prev_v = 1'b0;
    b_fetch_req = 1'b1;
    while (pulses < 17 && cyc < 200) begin
      tick();
      cyc++;
      if (b_busy) begin
        if (held && b_imem_addr !== held_addr) unstable++;
        held = 1'b1;
        held_addr = b_imem_addr;
      end else begin
        held = 1'b0;
      end
      if (b_ir_valid && prev_v) dbl++;
      prev_v = b_ir_valid;
      if (b_ir_valid) begin
        if (pulses > 0) check("b_gap", 32'(cyc - last), 32'd4);
        check("b_stream_ir", b_ir, mem[pulses]);
        check("b_stream_pcf", b_pc_fetched, 32'(pulses));
        last = cyc;
        pulses++;
        if (pulses == 17) b_fetch_req = 1'b0;
      end
    end
    check("b_pulses", 32'(pulses), 32'd17);
    check("b_addr_stable", 32'(unstable), 32'd0);
    check("b_no_double", 32'(dbl), 32'd0);
    check("b_pc17", b_pc, 32'd17);

    // Redirect to 5 from IDLE, then redirect to 12 mid-WAIT
    b_redirect_valid = 1'b1; b_redirect_pc = 32'd5;
    tick();
    b_redirect_valid = 1'b0;
    check("b_pc5", b_pc, 32'd5);
    b_fetch_req = 1'b1;
    tick();
    b_fetch_req = 1'b0;
    check("b_addr5", b_imem_addr, 32'd5);
    tick();
    b_redirect_valid = 1'b1; b_redirect_pc = 32'd12;
    tick();
    b_redirect_valid = 1'b0;
    check("b_mid_irv", 32'(b_ir_valid), 32'd0);
    check("b_mid_pc", b_pc, 32'd5);
    tick();
    check("b_cap_irv", 32'(b_ir_valid), 32'd1);
    check("b_cap_ir5", b_ir, mem[5]);
    check("b_cap_pcf", b_pc_fetched, 32'd5);
    check("b_redir_pc", b_pc, 32'd12);
    b_fetch_req = 1'b1;
    tick();
    b_fetch_req = 1'b0;
    wait_b_valid("b_irv12");
    check("b_ir12", b_ir, 32'h3000_0004);
    check("b_opc12", 32'(b_opcode), 32'd12);
    check("b_joff12", b_joff_sext, 32'd4);
    check("b_pc13", b_pc, 32'd13);

    // Redirect and fetch together in IDLE, then run off the end of memory
    b_redirect_valid = 1'b1; b_redirect_pc = 32'd1023; b_fetch_req = 1'b1;
    tick();
    b_redirect_valid = 1'b0;
    check("b_pc1023", b_pc, 32'd1023);
    check("b_nofetch", 32'(b_busy), 32'd0);
    tick();
    check("b_acc1023", 32'(b_busy), 32'd1);
    check("b_addr1023", b_imem_addr, 32'd1023);
    wait_b_valid("b_irv1023");
    check("b_ir1023", b_ir, 32'hDEAD_BEEF);
    check("b_pc1024", b_pc, 32'd1024);
    tick();
    check("b_fault", 32'(b_fault), 32'd1);
    check("b_fault_busy", 32'(b_busy), 32'd0);
    check("b_fault_irv", 32'(b_ir_valid), 32'd0);
    b_redirect_valid = 1'b1; b_redirect_pc = 32'd0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (b_ir_valid || b_busy) pulses++;
    end
    b_redirect_valid = 1'b0; b_fetch_req = 1'b0;
    check("b_fault_quiet", 32'(pulses), 32'd0);
    check("b_fault_pc", b_pc, 32'd1024);
    check("b_fault_ir", b_ir, 32'hDEAD_BEEF);
    check("b_fault_sticky", 32'(b_fault), 32'd1);

    // Reset asserted mid-WAIT
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    b_fetch_req = 1'b1;
    tick();
    b_fetch_req = 1'b0;
    tick();
    check("b_midwait_busy", 32'(b_busy), 32'd1);
    reset = 1'b1;
    #1;
    check("b_arst_busy", 32'(b_busy), 32'd0);
    check("b_arst_pc", b_pc, 32'd0);
    check("b_arst_addr", b_imem_addr, 32'd0);
    check("b_arst_ir", b_ir, 32'd0);
    check("b_arst_pcf", b_pc_fetched, 32'd0);
    check("b_arst_fault", 32'(b_fault), 32'd0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (b_ir_valid) pulses++;
    end
    check("b_arst_noirv", 32'(pulses), 32'd0);
    reset = 1'b0;
    b_fetch_req = 1'b1;
    tick();
    b_fetch_req = 1'b0;
    wait_b_valid("b_restart_irv");
    check("b_restart_ir", b_ir, 32'h0404_8000);
    check("b_restart_pcf", b_pc_fetched, 32'd0);
    check("b_restart_pc", b_pc, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Initiator/reader side of the word-addressed instruction memory. Owns the PC and issues fetch addresses.
- Waits a fixed memory latency, then captures the instruction into the IR. Exposes decoded instruction fields to the multi-cycle control unit.
- Also accepts PC redirects for branch, jmp, call and ret.
- Sits between the control FSM and the instruction memory.

Parameters:
- RESET_PC, 0, PC value after reset (word address).
- MEM_LATENCY, 1, clock edges from fetch acceptance to IR capture; legal range 1..15.
- MEM_DEPTH, 1024, number of instruction words; any PC >= MEM_DEPTH is out of range.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous reset, active-high.
- fetch_req  in  1  level request to fetch the instruction at the current PC.
- redirect_valid  in  1  load redirect_pc as the next PC.
- redirect_pc  in  32  target word address (branch, jmp, call or ret).
- imem_addr  out  32  address driven to instruction memory.
- imem_data  in  32  instruction word returned by memory.
- busy  out  1  high while a fetch is in flight.
- ir_valid  out  1  one-cycle pulse: IR was updated on the previous edge.
- ir  out  32  instruction register.
- pc  out  32  address of the next instruction to fetch.
- pc_fetched  out  32  address of the instruction currently in IR.
- pc_plus1  out  32  pc_fetched+1, the return address for call.
- opcode  out  6  ir[31:26].
- rd  out  4  ir[25:22].
- rs1  out  4  ir[21:18].
- rs2  out  4  ir[17:14].
- mode  out  2  ir[17:16].
- imm_sext  out  32  ir[15:0] sign-extended.
- joff_sext  out  32  ir[25:0] sign-extended.
- fault  out  1  sticky out-of-range fetch flag.

Behaviour:
- Reset (async, any state): pc=RESET_PC, imem_addr=RESET_PC, ir=0, pc_fetched=0, ir_valid=0, busy=0, fault=0, state=IDLE, pending redirect cleared.
- States: IDLE, WAIT, FAULT.
- IDLE, redirect_valid=1: pc <= redirect_pc. fetch_req is not accepted that cycle (redirect wins); the fetch starts on the next edge if fetch_req is still high.
- IDLE, fetch_req=1, no redirect, pc < MEM_DEPTH:
  - imem_addr <= pc, cnt <= MEM_LATENCY, busy <= 1, go WAIT.
- IDLE, fetch_req=1, pc >= MEM_DEPTH: fault <= 1, go FAULT. No IR update, no ir_valid.
- WAIT: cnt decrements each edge. On the edge where cnt==1:
  - ir <= imem_data, pc_fetched <= imem_addr, ir_valid <= 1, busy <= 0.
  - pc <= pending redirect if one is held, else pc+1. Go IDLE.
- Latency: with MEM_LATENCY=L, IR is valid L edges after the accepting edge; ir_valid is high in the cycle after capture. Back-to-back throughput is one instruction per L+1 cycles.
- redirect_valid during WAIT: the target is latched as the pending redirect (last one wins). The in-flight instruction is still delivered; the redirect is applied at capture instead of pc+1.
- fetch_req during WAIT: ignored; imem_addr holds stable through WAIT.
- FAULT: terminal until reset. Inputs are ignored, busy=0, ir holds its last value.
- Arithmetic: pc+1 is modulo 2^32; 0xFFFFFFFF wraps to 0, which is in range.
- Field outputs are combinational from ir and hold stable between captures. Fields overlap by format (R, I, J); the control unit selects the relevant ones by opcode.
- ir_valid is never high for two consecutive cycles.

Test Plan:
- Reset, mem[0]=0x04048000, fetch_req pulsed, L=1:
  - ir_valid pulses 2 cycles after the accepting edge.
  - ir=0x04048000, opcode=1, rd=0, rs1=1, rs2=2, pc=1, pc_fetched=0, pc_plus1=1.
- mem[3]=0x0C040004 fetched:
  - opcode=3, rs1=1, mode=0, imm_sext=4.
  - A word with ir[15:0]=0xFFFC gives imm_sext=0xFFFFFFFC.
- L=3, fetch_req held high continuously over words 0..16:
  - 17 ir_valid pulses spaced 4 cycles apart.
  - pc increments 0→17; imem_addr is stable throughout each WAIT.
- redirect_valid with redirect_pc=12, asserted mid-WAIT while fetching pc=5:
  - IR gets word 5, then pc=12.
  - The next fetch returns 0x30000004 with opcode=12 and joff_sext=4.
- Redirect and fetch_req asserted together in IDLE (redirect_pc=1023, MEM_DEPTH=1024):
  - pc=1023 and no fetch that cycle.
  - The next fetch succeeds; the following one raises fault, after which the block ignores all inputs until reset.
- Assert reset mid-WAIT:
  - All outputs return to reset values immediately, with no ir_valid pulse.
  - After reset releases, fetch restarts from RESET_PC.
